uart_cmd_frame_checker: RTL



---
 rtl/uart_cmd_frame_checker.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_frame_checker.sv
// Command frame checker between the UART receiver and transmitter: hunts for a header,
// collects and validates a fixed-format frame, and answers ACK/NAK over a ready/valid handshake.
module uart_cmd_frame_checker #(
    parameter logic [7:0] HDR_BYTE    = 8'hFF,
    parameter logic [7:0] DEV_ADDR    = 8'h00,
    parameter int         ARG_BYTES   = 1,
    parameter logic [7:0] CMD_MIN     = 8'h01,
    parameter logic [7:0] CMD_MAX     = 8'h07,
    parameter int         CHK_EN      = 1,
    parameter logic [7:0] ACK_BYTE    = 8'hAA,
    parameter logic [7:0] NAK_BYTE    = 8'hCC,
    parameter int         TIMEOUT_CYC = 100000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [7:0]             rx_data_i,
    input  logic                   rx_done,
    input  logic                   resp_ready_i,
    output logic                   resp_valid_o,
    output logic [7:0]             resp_data_o,
    output logic                   ver_done,
    output logic [7:0]             cmd_o,
    output logic [8*ARG_BYTES-1:0] arg_o,
    output logic [1:0]             err_code_o,
    output logic                   timeout_o,
    output logic [7:0]             err_cnt_o
);

    localparam int FRAME_LEN = 3 + ARG_BYTES + CHK_EN;
    localparam int IDX_W     = 4;
    localparam int TMO_W     = $clog2(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] ADDR_IDX = IDX_W'(1);
    localparam logic [IDX_W-1:0] CMD_IDX  = IDX_W'(2 + ARG_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // First failing check wins: address, then command range, then checksum.
    function automatic logic [1:0] frame_verdict(input logic [7:0] addr, input logic [7:0] cmd,
                                                 input logic chk_ok);
        if (addr != DEV_ADDR) begin
            return 2'd1;
        end else if ((cmd < CMD_MIN) || (cmd > CMD_MAX)) begin
            return 2'd2;
        end else if (!chk_ok) begin
            return 2'd3;
        end else begin
            return 2'd0;
        end
    endfunction

    state_t                 state_r, state_s;
    logic [IDX_W-1:0]       idx_r;
    logic [7:0]             xor_r;
    logic [7:0]             addr_r;
    logic [7:0]             cmd_buf_r;
    logic [8*ARG_BYTES-1:0] arg_buf_r;
    logic [TMO_W-1:0]       tmo_r;
    logic                   resp_valid_r;
    logic [7:0]             resp_data_r;
    logic                   ver_done_r;
    logic [7:0]             cmd_r;
    logic [8*ARG_BYTES-1:0] arg_r;
    logic [1:0]             err_code_r;
    logic                   timeout_r;
    logic [7:0]             err_cnt_r;
    logic                   start_s, frame_end_s, tmo_fire_s, chk_ok_s;
    logic [7:0]             cmd_s;
    logic [1:0]             verdict_s;

    // Without a checksum the last byte is the command itself, so it is taken straight off the bus.
    assign cmd_s     = (CHK_EN != 0) ? cmd_buf_r : rx_data_i;
    assign chk_ok_s  = (CHK_EN == 0) || (rx_data_i == xor_r);
    assign verdict_s = frame_verdict(addr_r, cmd_s, chk_ok_s);

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic and the one-cycle control strobes.
    always_comb begin
        state_s     = state_r;
        start_s     = 1'b0;
        frame_end_s = 1'b0;
        tmo_fire_s  = 1'b0;
        case (state_r)
            ST_HUNT: begin
                if (rx_done && (rx_data_i == HDR_BYTE)) begin
                    state_s = ST_COLLECT;
                    start_s = 1'b1;
                end else begin
                    state_s = ST_HUNT;
                end
            end
            ST_COLLECT: begin
                if (rx_done) begin
                    if (idx_r == LAST_IDX) begin
                        state_s     = ST_RESP;
                        frame_end_s = 1'b1;
                    end else begin
                        state_s = ST_COLLECT;
                    end
                end else if (tmo_r == TMO_LAST) begin
                    state_s    = ST_HUNT;
                    tmo_fire_s = 1'b1;
                end else begin
                    state_s = ST_COLLECT;
                end
            end
            ST_RESP: begin
                // A header landing in the transfer cycle already opens the next frame.
                if (resp_ready_i) begin
                    if (rx_done && (rx_data_i == HDR_BYTE)) begin
                        state_s = ST_COLLECT;
                        start_s = 1'b1;
                    end else begin
                        state_s = ST_HUNT;
                    end
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_HUNT;
        endcase
    end

    // Frame byte capture, byte index and running checksum.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_r     <= {IDX_W{1'b0}};
            xor_r     <= 8'h00;
            addr_r    <= 8'h00;
            cmd_buf_r <= 8'h00;
            arg_buf_r <= {(8*ARG_BYTES){1'b0}};
        end else if (start_s) begin
            idx_r <= IDX_W'(1);
            xor_r <= HDR_BYTE;
        end else if (frame_end_s || tmo_fire_s) begin
            idx_r <= {IDX_W{1'b0}};
        end else if ((state_r == ST_COLLECT) && rx_done) begin
            idx_r <= idx_r + IDX_W'(1);
            xor_r <= xor_fold(xor_r, rx_data_i);
            if (idx_r == ADDR_IDX) begin
                addr_r <= rx_data_i;
            end
            if (idx_r == CMD_IDX) begin
                cmd_buf_r <= rx_data_i;
            end
            for (int k = 0; k < ARG_BYTES; k++) begin
                if (idx_r == IDX_W'(2 + k)) begin
                    arg_buf_r[8*(ARG_BYTES-1-k) +: 8] <= rx_data_i;
                end
            end
        end
    end

    // Inter-byte timeout counter, only running while a frame is open.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tmo_r <= {TMO_W{1'b0}};
        end else if ((state_r == ST_COLLECT) && !rx_done && !tmo_fire_s) begin
            tmo_r <= tmo_r + TMO_W'(1'b1);
        end else begin
            tmo_r <= {TMO_W{1'b0}};
        end
    end

    // Response handshake, decoded outputs, pulses and error counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_r <= 1'b0;
            resp_data_r  <= NAK_BYTE;
            ver_done_r   <= 1'b0;
            cmd_r        <= 8'h00;
            arg_r        <= {(8*ARG_BYTES){1'b0}};
            err_code_r   <= 2'd0;
            timeout_r    <= 1'b0;
            err_cnt_r    <= 8'h00;
        end else begin
            ver_done_r <= 1'b0;
            timeout_r  <= tmo_fire_s;
            if (frame_end_s) begin
                resp_valid_r <= 1'b1;
                err_code_r   <= verdict_s;
                if (verdict_s == 2'd0) begin
                    resp_data_r <= ACK_BYTE;
                    ver_done_r  <= 1'b1;
                    cmd_r       <= cmd_s;
                    arg_r       <= arg_buf_r;
                end else begin
                    resp_data_r <= NAK_BYTE;
                end
            end else if ((state_r == ST_RESP) && resp_ready_i) begin
                resp_valid_r <= 1'b0;
            end
            if ((tmo_fire_s || (frame_end_s && (verdict_s != 2'd0))) && (err_cnt_r != 8'hFF)) begin
                err_cnt_r <= err_cnt_r + 8'd1;
            end
        end
    end

    assign resp_valid_o = resp_valid_r;
    assign resp_data_o  = resp_data_r;
    assign ver_done     = ver_done_r;
    assign cmd_o        = cmd_r;
    assign arg_o        = arg_r;
    assign err_code_o   = err_code_r;
    assign timeout_o    = timeout_r;
    assign err_cnt_o    = err_cnt_r;

endmodule
